// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-FF synchroniser, settle FSM and registered level/press/release pulses per channel.
// Define KEY_LONGPRESS_EN to add the per-channel long-press pulse; otherwise long_press is tied to 0.
module key_debounce_multi #(
  parameter int CH           = 4,
  parameter int DEBOUNCE_CYC = 1000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int LONG_CYC     = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] key,
  output logic [CH-1:0] key_state,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] release_pulse,
  output logic [CH-1:0] long_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [CH-1:0] sync_p0;
  logic [CH-1:0] sync_p1;
  logic [CH-1:0] act;

  // Stage p0/p1: synchroniser, reset to the released pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {CH{ACTIVE_LOW}};
      sync_p1 <= {CH{ACTIVE_LOW}};
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
    end
  end

  assign act = sync_p1 ^ {CH{ACTIVE_LOW}};

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          lvl_d = 1'b0;
          if (act[g]) state_d = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!act[g]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = HELD;
            cnt_d   = '0;
            press_d = 1'b1;
            lvl_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          cnt_d = '0;
          lvl_d = 1'b1;
          if (!act[g]) state_d = RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (act[g]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
            rel_d   = 1'b1;
            lvl_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          lvl_d   = 1'b0;
        end
      endcase
    end

    // Stage p2: registered FSM state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign key_state[g]     = lvl_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = rel_q;

`ifdef KEY_LONGPRESS_EN
    localparam int LCNT_W = $clog2(LONG_CYC);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_CYC - 1);

    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              ldone_q, ldone_d;
    logic              long_q, long_d;

    // lcnt only advances while stably held; a release glitch pauses it without clearing
    always_comb begin
      lcnt_d  = lcnt_q;
      ldone_d = ldone_q;
      long_d  = 1'b0;
      case (state_q)
        IDLE: begin
          lcnt_d  = '0;
          ldone_d = 1'b0;
        end
        PRESS_WAIT: begin
          if (state_d == HELD) begin
            lcnt_d  = '0;
            ldone_d = 1'b0;
          end
        end
        HELD: begin
          if (!ldone_q) begin
            if (lcnt_q == LCNT_MAX) begin
              long_d  = 1'b1;
              ldone_d = 1'b1;
            end else begin
              lcnt_d = lcnt_q + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          lcnt_d = lcnt_q;
        end
        default: begin
          lcnt_d  = '0;
          ldone_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lcnt_q  <= '0;
        ldone_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        lcnt_q  <= lcnt_d;
        ldone_q <= ldone_d;
        long_q  <= long_d;
      end
    end

    assign long_press[g] = long_q;
`else
    assign long_press[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: level/run-length reference model checked every cycle plus literal latency checks.
module tb_key_debounce_multi;

  localparam int CH   = 4;
  localparam int DC   = 16;
  localparam int LONG = 64;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] key;
  logic [CH-1:0] key_state;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] long_press;

  key_debounce_multi #(
    .CH(CH), .DEBOUNCE_CYC(DC), .ACTIVE_LOW(1'b1), .LONG_CYC(LONG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_state(key_state),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act_v, exp_v);
    end
  endtask

  // Reference model: the debounced level flips once the synchronised input has
  // disagreed with it for DC+1 consecutive clock edges.
  logic [CH-1:0] m_s1, m_s2, m_lvl;
  logic [CH-1:0] exp_state, exp_press, exp_rel, exp_long;
  int            m_run   [CH];
  int            m_held  [CH];
  bit            m_ldone [CH];

  task automatic m_reset();
    m_s1 = '1; m_s2 = '1; m_lvl = '0;
    exp_state = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_held[c] = 0; m_ldone[c] = 1'b0;
    end
  endtask

  task automatic m_step();
    for (int c = 0; c < CH; c++) begin
      bit v        = ~m_s2[c];
      bit held_pre = m_lvl[c] && (m_run[c] == 0);
      exp_press[c] = 1'b0;
      exp_rel[c]   = 1'b0;
      exp_long[c]  = 1'b0;
      if (v != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == DC + 1) begin
          m_lvl[c] = v;
          m_run[c] = 0;
          if (v) begin
            exp_press[c] = 1'b1;
            m_held[c]    = 0;
            m_ldone[c]   = 1'b0;
          end else begin
            exp_rel[c] = 1'b1;
          end
        end
      end else begin
        m_run[c] = 0;
      end
`ifdef KEY_LONGPRESS_EN
      if (held_pre && !m_ldone[c]) begin
        m_held[c]++;
        if (m_held[c] == LONG) begin
          exp_long[c] = 1'b1;
          m_ldone[c]  = 1'b1;
        end
      end
`else
      if (held_pre) m_held[c] = 0;
`endif
    end
    m_s2 = m_s1;
    m_s1 = key;
    exp_state = m_lvl;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  int npress [CH] = '{default: 0};
  int nrel   [CH] = '{default: 0};
  int nlong  [CH] = '{default: 0};
  int lpress [CH] = '{default: -1};
  int lrel   [CH] = '{default: -1};
  int llong  [CH] = '{default: -1};

  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      chk("key_state", 32'(key_state), 32'(exp_state));
      chk("press_pulse", 32'(press_pulse), 32'(exp_press));
      chk("release_pulse", 32'(release_pulse), 32'(exp_rel));
      chk("long_press", 32'(long_press), 32'(exp_long));
      for (int c = 0; c < CH; c++) begin
        if (press_pulse[c])   begin npress[c]++; lpress[c] = cyc; end
        if (release_pulse[c]) begin nrel[c]++;   lrel[c]   = cyc; end
        if (long_press[c])    begin nlong[c]++;  llong[c]  = cyc; end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t, q, r, b0, b1, b2, b3;

  initial begin
    rst_n = 1'b0;
    key   = 4'b1111;
    step(3);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_pulses", 32'({press_pulse, release_pulse, long_press}), 32'h0);
    rst_n = 1'b1;
    step(100);
    chk("idle_press_cnt", 32'(npress[0] + npress[1] + npress[2] + npress[3]), 32'd0);
    chk("idle_rel_cnt", 32'(nrel[0] + nrel[1] + nrel[2] + nrel[3]), 32'd0);

    // Clean press then release on channel 0
    key[0] = 1'b0; t = cyc;
    step(30);
    chk("p0_latency", 32'(lpress[0] - t), 32'd19);
    chk("p0_count", 32'(npress[0]), 32'd1);
    chk("p0_level", 32'(key_state[0]), 32'd1);
    step(20);
    key[0] = 1'b1; t = cyc;
    step(30);
    chk("r0_latency", 32'(lrel[0] - t), 32'd19);
    chk("r0_count", 32'(nrel[0]), 32'd1);

    // Bouncing channel 1: no pulse until it settles
    b1 = npress[1]; b0 = nrel[1];
    for (int i = 0; i < 40; i++) begin
      key[1] = i[0];
      step(5);
    end
    chk("bounce_no_press", 32'(npress[1]), 32'(b1));
    chk("bounce_no_rel", 32'(nrel[1]), 32'(b0));
    key[1] = 1'b0; t = cyc;
    step(30);
    chk("bounce_press_cnt", 32'(npress[1]), 32'(b1 + 1));
    chk("bounce_latency", 32'(lpress[1] - t), 32'd19);
    key[1] = 1'b1;
    step(30);

    // Simultaneous press on channels 3:2
    b0 = npress[0]; b1 = npress[1];
    key[3:2] = 2'b00; t = cyc;
    step(30);
    chk("p2_latency", 32'(lpress[2] - t), 32'd19);
    chk("p3_latency", 32'(lpress[3] - t), 32'd19);
    chk("p0_untouched", 32'(npress[0]), 32'(b0));
    chk("p1_untouched", 32'(npress[1]), 32'(b1));

    // Long hold on channel 0 with a short release glitch after 30 held cycles
    b2 = nlong[0]; b3 = nrel[0];
    key[0] = 1'b0; t = cyc; q = t + 19;
    step(48);
    key[0] = 1'b1;
    step(5);
    key[0] = 1'b0;
    step(160);
    chk("glitch_no_release", 32'(nrel[0]), 32'(b3));
    chk("lp_press_edge", 32'(lpress[0] - t), 32'd19);
`ifdef KEY_LONGPRESS_EN
    chk("long_count", 32'(nlong[0]), 32'(b2 + 1));
    chk("long_edge", 32'(llong[0] - q), 32'd69);
`else
    chk("long_count", 32'(nlong[0]), 32'(b2));
`endif
    key[0] = 1'b1;
    step(30);

    // Reset during PRESS_WAIT at cnt=10 while channels 3:2 are held
    key[0] = 1'b0; t = cyc;
    step(13);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", 32'(key_state), 32'h0);
    chk("midrst_pulses", 32'({press_pulse, release_pulse, long_press}), 32'h0);
    step(3);
    rst_n = 1'b1; r = cyc;
    step(30);
    chk("postrst_p0", 32'(lpress[0] - r), 32'd19);
    chk("postrst_p2", 32'(lpress[2] - r), 32'd19);
    chk("postrst_p3", 32'(lpress[3] - r), 32'd19);
    chk("postrst_level", 32'(key_state), 32'hD);

    key = 4'b1111;
    step(30);
    chk("final_level", 32'(key_state), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
